rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Sequencing initiator for the single-port register file bus (`rf_en`, `r_or_w`, `reg_addr`, data in/out). It accepts one operand/result request at a time through a valid/ready handshake. It serializes the request into up to two reads and one write on the shared bus, captures the read data, and returns both operands on a valid/ready response channel. It sits between the datapath control and the register file, and is the only block that drives the register-file bus.

## Interface
Parameters:
- `WIDTH`, 16, data width of register contents.
- `ADDR_W`, 4, register address width (16 registers).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  controller can accept a request.
- `req_rd_a`  in  1  read operand A.
- `req_rd_b`  in  1  read operand B.
- `req_wr`  in  1  write result.
- `req_addr_a`  in  ADDR_W  operand A address.
- `req_addr_b`  in  ADDR_W  operand B address.
- `req_addr_d`  in  ADDR_W  destination address.
- `req_wdata`  in  WIDTH  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_a`  out  WIDTH  captured operand A; 0 if it was not read.
- `rsp_b`  out  WIDTH  captured operand B; 0 if it was not read.
- `rsp_err`  out  1  write-verify mismatch (see Configuration).
- `rf_en`  out  1  register-file enable.
- `r_or_w`  out  1  1 = write, 0 = read.
- `reg_addr`  out  ADDR_W  register address.
- `rf_wdata`  out  WIDTH  data to the register file.
- `rf_rdata`  in  WIDTH  data from the register file; combinational, and high-Z when not reading.

## Operation
- States: IDLE, RD_A, RD_B, WR, VFY (macro only), RSP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch all request fields.
  - Go to the first enabled phase, in the order RD_A → RD_B → WR → VFY.
  - If no phase is enabled, go directly to RSP.
- RD_A / RD_B:
  - Drive `rf_en`=1, `r_or_w`=0, `reg_addr`=latched address.
  - Capture `rf_rdata` into `rsp_a` or `rsp_b` at the closing edge.
  - Then go to the next enabled phase.
- WR:
  - Drive `rf_en`=1, `r_or_w`=1, `reg_addr`=`addr_d`, `rf_wdata`=latched data.
  - Then go to VFY (macro defined) or RSP.
- RSP:
  - `rsp_valid`=1; outputs are held stable until `rsp_ready`.
  - On `rsp_valid`&&`rsp_ready`, return to IDLE.
  - `req_ready` stays 0 throughout RSP, so there is no request/response overlap.
- Reads always precede the write. If A or B equals D, the old value is returned.
- Bus outputs in any state not driving the bus: `rf_en`=0, `r_or_w`=0, `reg_addr`=0, `rf_wdata`=0.
- `rf_rdata` is sampled only in RD_A, RD_B and VFY. High-Z at any other time is ignored.
- Captured operand registers are cleared to 0 on request acceptance, so unread operands report 0.

## Timing
- Bus outputs are registered from state; each bus phase lasts exactly one cycle.
- Latency:
  - Acceptance edge to `rsp_valid` high = 1 + N cycles, where N = number of enabled phases (including VFY).
  - N=0 gives `rsp_valid` on the cycle after acceptance.
- The earliest next acceptance is the cycle after the response handshake.
- Reset values (async, immediate): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_a`=`rsp_b`=0, `rsp_err`=0, all bus outputs 0.
- Reset asserted mid-operation:
  - `rf_en` drops asynchronously.
  - A write in flight is abandoned. No partial response is produced.
- Request fields are don't-care when `req_valid`=0 or `req_ready`=0.

## Configuration
- Macro: `RF_ACCESS_CTRL_WRVERIFY_EN`.
- Defined:
  - After WR, the VFY state drives `rf_en`=1, `r_or_w`=0, `reg_addr`=`addr_d`, and compares `rf_rdata` against the latched write data.
  - `rsp_err`=1 on mismatch; it is held with the response and cleared on acceptance.
  - VFY adds one cycle of latency when `req_wr`=1.
- Undefined:
  - There is no VFY state, and `rsp_err` is tied to 0.

## Test plan
- Reset release, then a request with rd_a=1, addr_a=3, rf model holding reg3=16'h1234.
  - Required: `rsp_valid` 2 cycles after acceptance, `rsp_a`=16'h1234, `rsp_b`=0.
- Full request rd_a(addr 1 = 16'h0011), rd_b(addr 2 = 16'h0022), wr(addr 1, 16'hBEEF).
  - Required: bus sequence read1, read2, write1.
  - Required: `rsp_a`=16'h0011 (old value), `rsp_b`=16'h0022, and the model then holds reg1=16'hBEEF.
- All phase enables 0.
  - Required: `rf_en` never asserts, `rsp_valid` the cycle after acceptance, `rsp_a`=`rsp_b`=0.
- Hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_valid`, `rsp_a` and `rsp_b` remain stable and `req_ready`=0.
  - Required: after the handshake, IDLE follows with `req_ready`=1 the next cycle.
- Assert `rst_n`=0 during WR.
  - Required: `rf_en`=0 within the same cycle, all outputs at reset values, and no `rsp_valid` after release.
- With the macro defined, a write of 16'hA5A5 to a model that sticks bit0 at 0.
  - Required: `rsp_err`=1.
  - Required: a correct model gives `rsp_err`=0, and latency rises by one cycle.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// rf_access_ctrl
//
// Sequencing initiator for the single-port register-file bus. One request is
// accepted at a time over a valid/ready handshake. It is serialized into up to
// two reads (operand A, operand B) and one write (result) on the shared bus.
// Both captured operands are then returned on a valid/ready response channel.
// This block is the only driver of the register-file bus.
//
// Optional feature macro: RF_ACCESS_CTRL_WRVERIFY_EN
//   When defined, every write is followed by a read-back of the destination
//   register (VFY phase). rsp_err reports whether the read-back differed from
//   the data written. When undefined, there is no VFY phase and rsp_err is 0.
//
// Parameters
//   WIDTH   data width of a register
//   ADDR_W  register address width
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_rd_a, req_rd_b, req_wr phase enables for the request
//   req_addr_a/b/d, req_wdata  operand addresses, destination, write data
//   rsp_valid / rsp_ready      response handshake
//   rsp_a, rsp_b               captured operands (0 when not read)
//   rsp_err                    write-verify mismatch flag
//   rf_en, r_or_w, reg_addr    register-file bus control (r_or_w: 1 = write)
//   rf_wdata                   register-file write data
//   rf_rdata                   register-file read data (combinational,
//                              only meaningful while a read is on the bus)
//
// Timing model
//   The state register runs one cycle ahead of the bus. Each bus phase state
//   lasts one cycle; the bus registers are loaded from the current state, so
//   the matching bus cycle follows one clock later. Read data is captured at
//   the closing edge of that bus cycle. This gives an acceptance-to-rsp_valid
//   latency of 1 + (number of enabled bus phases).
// -----------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd_a,
    input  logic              req_rd_b,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [ADDR_W-1:0] req_addr_d,
    input  logic [WIDTH-1:0]  req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_a,
    output logic [WIDTH-1:0]  rsp_b,
    output logic              rsp_err,

    output logic              rf_en,
    output logic              r_or_w,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [WIDTH-1:0]  rf_wdata,
    input  logic [WIDTH-1:0]  rf_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
        S_VFY  = 3'd4,
`endif
        S_RSP  = 3'd5
    } state_t;

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_t              state_reg;
    // Which phase is physically on the bus this cycle (trails state_reg by one).
    state_t              bus_phase_reg;

    logic                rd_b_en_reg;
    logic                wr_en_reg;
    logic [ADDR_W-1:0]   addr_a_reg;
    logic [ADDR_W-1:0]   addr_b_reg;
    logic [ADDR_W-1:0]   addr_d_reg;
    logic [WIDTH-1:0]    wdata_reg;

    // Registered outputs
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [WIDTH-1:0]    rsp_a_reg;
    logic [WIDTH-1:0]    rsp_b_reg;
    logic                rf_en_reg;
    logic                r_or_w_reg;
    logic [ADDR_W-1:0]   reg_addr_reg;
    logic [WIDTH-1:0]    rf_wdata_reg;

    // -------------------------------------------------------------------------
    // Phase sequencing: each "after" signal picks the next enabled phase in
    // the fixed order RD_A -> RD_B -> WR -> VFY -> RSP.
    // -------------------------------------------------------------------------
    state_t first_phase_next;
    state_t after_rd_a_next;
    state_t after_rd_b_next;
    state_t after_wr_next;

    always_comb begin
        // From IDLE the live request enables are used (nothing latched yet).
        if (req_rd_a) begin
            first_phase_next = S_RD_A;
        end else if (req_rd_b) begin
            first_phase_next = S_RD_B;
        end else if (req_wr) begin
            first_phase_next = S_WR;
        end else begin
            first_phase_next = S_RSP;
        end

        if (rd_b_en_reg) begin
            after_rd_a_next = S_RD_B;
        end else if (wr_en_reg) begin
            after_rd_a_next = S_WR;
        end else begin
            after_rd_a_next = S_RSP;
        end

        if (wr_en_reg) begin
            after_rd_b_next = S_WR;
        end else begin
            after_rd_b_next = S_RSP;
        end

`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
        after_wr_next = S_VFY;
`else
        after_wr_next = S_RSP;
`endif
    end

`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
    // -------------------------------------------------------------------------
    // Write verify: per-bit difference between read-back and written data.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] vfy_diff;
    logic             rsp_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_vfy_diff
            assign vfy_diff[gi] = rf_rdata[gi] ^ wdata_reg[gi];
        end
    endgenerate
`endif

    // -------------------------------------------------------------------------
    // Main FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            bus_phase_reg <= S_IDLE;
            rd_b_en_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            addr_d_reg    <= '0;
            wdata_reg     <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_a_reg     <= '0;
            rsp_b_reg     <= '0;
            rf_en_reg     <= 1'b0;
            r_or_w_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            rf_wdata_reg  <= '0;
`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            // Bus is idle (all zero) unless the current state drives a phase.
            rf_en_reg     <= 1'b0;
            r_or_w_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            rf_wdata_reg  <= '0;
            bus_phase_reg <= S_IDLE;

            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        rd_b_en_reg   <= req_rd_b;
                        wr_en_reg     <= req_wr;
                        addr_a_reg    <= req_addr_a;
                        addr_b_reg    <= req_addr_b;
                        addr_d_reg    <= req_addr_d;
                        wdata_reg     <= req_wdata;
                        // Unread operands must report 0.
                        rsp_a_reg     <= '0;
                        rsp_b_reg     <= '0;
`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
                        rsp_err_reg   <= 1'b0;
`endif
                        req_ready_reg <= 1'b0;
                        state_reg     <= first_phase_next;
                    end
                end

                S_RD_A: begin
                    rf_en_reg     <= 1'b1;
                    reg_addr_reg  <= addr_a_reg;
                    bus_phase_reg <= S_RD_A;
                    state_reg     <= after_rd_a_next;
                end

                S_RD_B: begin
                    rf_en_reg     <= 1'b1;
                    reg_addr_reg  <= addr_b_reg;
                    bus_phase_reg <= S_RD_B;
                    state_reg     <= after_rd_b_next;
                end

                S_WR: begin
                    rf_en_reg     <= 1'b1;
                    r_or_w_reg    <= 1'b1;
                    reg_addr_reg  <= addr_d_reg;
                    rf_wdata_reg  <= wdata_reg;
                    bus_phase_reg <= S_WR;
                    state_reg     <= after_wr_next;
                end

`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
                S_VFY: begin
                    rf_en_reg     <= 1'b1;
                    reg_addr_reg  <= addr_d_reg;
                    bus_phase_reg <= S_VFY;
                    state_reg     <= S_RSP;
                end
`endif

                S_RSP: begin
                    // rsp_valid rises on the first edge in RSP, which is also
                    // the edge that captures the last bus phase's read data.
                    if (rsp_valid_reg && rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end else begin
                        rsp_valid_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase

            // Read data is only looked at while a read phase is on the bus;
            // rf_rdata may float at any other time.
            case (bus_phase_reg)
                S_RD_A:  rsp_a_reg <= rf_rdata;
                S_RD_B:  rsp_b_reg <= rf_rdata;
`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
                S_VFY:   rsp_err_reg <= |vfy_diff;
`endif
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_a     = rsp_a_reg;
    assign rsp_b     = rsp_b_reg;
    assign rf_en     = rf_en_reg;
    assign r_or_w    = r_or_w_reg;
    assign reg_addr  = reg_addr_reg;
    assign rf_wdata  = rf_wdata_reg;

`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
    assign rsp_err   = rsp_err_reg;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_access_ctrl
//
// Self-checking bench for rf_access_ctrl. A behavioural register-file model
// answers the bus. A shadow copy of the register contents predicts operands,
// the bus operation list, latency, write-verify result and final contents of
// every transaction. Directed steps come first, then randomized requests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_access_ctrl;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

`ifdef RF_ACCESS_CTRL_WRVERIFY_EN
    localparam bit VFY_ON = 1'b1;
`else
    localparam bit VFY_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid, req_ready;
    logic              req_rd_a, req_rd_b, req_wr;
    logic [ADDR_W-1:0] req_addr_a, req_addr_b, req_addr_d;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [WIDTH-1:0]  rsp_a, rsp_b;
    logic              rsp_err;
    logic              rf_en, r_or_w;
    logic [ADDR_W-1:0] reg_addr;
    logic [WIDTH-1:0]  rf_wdata;
    wire  [WIDTH-1:0]  rf_rdata;

    always #5 clk = ~clk;

    rf_access_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_a   (req_rd_a),
        .req_rd_b   (req_rd_b),
        .req_wr     (req_wr),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .req_addr_d (req_addr_d),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_a      (rsp_a),
        .rsp_b      (rsp_b),
        .rsp_err    (rsp_err),
        .rf_en      (rf_en),
        .r_or_w     (r_or_w),
        .reg_addr   (reg_addr),
        .rf_wdata   (rf_wdata),
        .rf_rdata   (rf_rdata)
    );

    // ---------------- register-file model ----------------
    logic [WIDTH-1:0]  rf_mem [NREG];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [WIDTH-1:0]  pl_data = '0;
    logic              stuck0 = 1'b0;      // read path forces bit0 to 0
    logic [WIDTH-1:0]  rd_word;

    always @(posedge clk) begin
        if (pl_en) rf_mem[pl_addr] <= pl_data;
        else if (rf_en && r_or_w) rf_mem[reg_addr] <= rf_wdata;
    end

    assign rd_word  = stuck0 ? (rf_mem[reg_addr] & {{(WIDTH-1){1'b1}}, 1'b0}) : rf_mem[reg_addr];
    assign rf_rdata = (rf_en && !r_or_w) ? rd_word : {WIDTH{1'bz}};

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } bus_op_t;

    bus_op_t bus_q[$];
    int      idle_bad = 0;
    int      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rf_en) bus_q.push_back({r_or_w, reg_addr, (r_or_w ? rf_wdata : {WIDTH{1'b0}})});
        else if (r_or_w || reg_addr != '0 || rf_wdata != '0) idle_bad++;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] ref_mem [NREG];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_read(input logic [WIDTH-1:0] v);
        return stuck0 ? (v & {{(WIDTH-1){1'b1}}, 1'b0}) : v;
    endfunction

    // Reset-value vector: rf_en, r_or_w, reg_addr, rf_wdata, req_ready,
    // rsp_valid, rsp_a, rsp_b, rsp_err.
    function automatic logic [63:0] out_vec();
        return {7'd0, rf_en, r_or_w, reg_addr, rf_wdata, req_ready, rsp_valid, rsp_a, rsp_b, rsp_err};
    endfunction
    localparam logic [63:0] RESET_VEC = {7'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0};

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready_wait"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic run_txn(input bit a, input bit b, input bit w,
                           input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                           input logic [ADDR_W-1:0] ad, input logic [WIDTH-1:0] wd,
                           input int hold, input string tag);
        logic [WIDTH-1:0] ea, eb, readback;
        bit      eerr;
        int      elat, acc, start, idle0, nops;
        bus_op_t exp_ops[$];

        // Reference prediction: reads see the old contents, then the write lands.
        ea       = a ? model_read(ref_mem[aa]) : '0;
        eb       = b ? model_read(ref_mem[ab]) : '0;
        readback = model_read(wd);
        eerr     = VFY_ON && w && (readback != wd);
        elat     = 1 + int'(a) + int'(b) + int'(w) + int'(w && VFY_ON);
        if (a) exp_ops.push_back({1'b0, aa, {WIDTH{1'b0}}});
        if (b) exp_ops.push_back({1'b0, ab, {WIDTH{1'b0}}});
        if (w) exp_ops.push_back({1'b1, ad, wd});
        if (w && VFY_ON) exp_ops.push_back({1'b0, ad, {WIDTH{1'b0}}});
        if (w) ref_mem[ad] = wd;

        wait_ready(tag);
        start      = bus_q.size();
        idle0      = idle_bad;
        req_valid  = 1'b1;
        req_rd_a   = a;   req_rd_b   = b;   req_wr    = w;
        req_addr_a = aa;  req_addr_b = ab;  req_addr_d = ad;
        req_wdata  = wd;
        @(negedge clk);
        acc = cyc;
        // Fields become don't-care once accepted.
        req_valid  = 1'b0;
        {req_rd_a, req_rd_b, req_wr} = 3'($urandom);
        req_addr_a = ADDR_W'($urandom); req_addr_b = ADDR_W'($urandom);
        req_addr_d = ADDR_W'($urandom); req_wdata  = WIDTH'($urandom);
        chk({tag, "_busy"}, {63'd0, req_ready}, 64'd0);

        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        chk({tag, "_latency"}, rsp_valid ? 64'(cyc - acc) : 64'hFFFF, 64'(elat));
        chk({tag, "_rsp_a"}, 64'(rsp_a), 64'(ea));
        chk({tag, "_rsp_b"}, 64'(rsp_b), 64'(eb));
        chk({tag, "_rsp_err"}, {63'd0, rsp_err}, {63'd0, eerr});

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d", tag, h), 64'({rsp_valid, req_ready, rsp_a, rsp_b}),
                64'({1'b1, 1'b0, ea, eb}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_after_hs"}, {62'd0, rsp_valid, req_ready}, 64'd1);

        nops = bus_q.size() - start;
        chk({tag, "_nops"}, 64'(nops), 64'(exp_ops.size()));
        for (int k = 0; k < nops && k < exp_ops.size(); k++)
            chk($sformatf("%s_op%0d", tag, k), 64'(bus_q[start + k]), 64'(exp_ops[k]));
        chk({tag, "_idle_bus"}, 64'(idle_bad - idle0), 64'd0);
        $display("txn %s rd_a=%0d rd_b=%0d wr=%0d a=%0h b=%0h err=%0d lat=%0d", tag, a, b, w,
                 rsp_a, rsp_b, rsp_err, elat);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int found;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_rd_a = 1'b0; req_rd_b = 1'b0; req_wr = 1'b0;
        req_addr_a = '0; req_addr_b = '0; req_addr_d = '0; req_wdata = '0;

        // Preload registers while held in reset.
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = ADDR_W'(i);
            case (i)
                1:       pl_data = 16'h0011;
                2:       pl_data = 16'h0022;
                3:       pl_data = 16'h1234;
                default: pl_data = WIDTH'($urandom);
            endcase
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        chk("reset_outputs", out_vec(), RESET_VEC);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_release", out_vec(), RESET_VEC);

        // Single read of A.
        run_txn(1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 16'h0, 0, "rd_a_only");
        // Full request with D == A: old value returned, then write lands.
        run_txn(1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 4'd1, 16'hBEEF, 0, "full");
        chk("reg1_written", 64'(rf_mem[1]), 64'h0000_0000_0000_BEEF);
        // No phases at all.
        run_txn(1'b0, 1'b0, 1'b0, 4'd5, 4'd6, 4'd7, 16'h1111, 0, "no_phase");
        // Back-pressure on the response.
        run_txn(1'b1, 1'b1, 1'b0, 4'd1, 4'd3, 4'd0, 16'h0, 5, "hold5");

        // Reset during the write phase.
        wait_ready("rst_wr");
        req_valid = 1'b1; req_rd_a = 1'b1; req_rd_b = 1'b0; req_wr = 1'b1;
        req_addr_a = 4'd4; req_addr_d = 4'd9; req_wdata = 16'hDEAD;
        @(negedge clk);
        req_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (rf_en && r_or_w) found = 1;
            else @(negedge clk);
        end
        chk("rst_wr_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_async", out_vec(), RESET_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || rf_en) found++;
        end
        chk("rst_wr_quiet", 64'(found), 64'd0);
        chk("rst_wr_abandoned", 64'(rf_mem[9]), 64'(ref_mem[9]));
        $display("txn rst_during_wr done");

        // Write with a faulty read path, then with a healthy one.
        stuck0 = 1'b1;
        run_txn(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 16'hA5A5, 0, "vfy_stuck");
        stuck0 = 1'b0;
        run_txn(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd8, 16'hA5A5, 0, "vfy_ok");
        run_txn(1'b1, 1'b1, 1'b0, 4'd7, 4'd8, 4'd0, 16'h0, 1, "readback");

        // Randomized requests.
        for (int t = 0; t < 40; t++) begin
            stuck0 = ($urandom_range(0, 7) == 0);
            run_txn(1'($urandom), 1'($urandom), 1'($urandom),
                    ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
                    WIDTH'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
        end
        stuck0 = 1'b0;

        for (int i = 0; i < NREG; i++)
            chk($sformatf("final_reg%0d", i), 64'(rf_mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
